// File: rtl/rst_run_ctrl.sv
// Reset/run sequencer: synchronises rstn, releases staggered core resets,
// then counts run cycles until the core halts or the cycle budget runs out.
module rst_run_ctrl #(
    parameter int NUM_RST    = 3,
    parameter int STRETCH    = 4,
    parameter int STAGGER    = 2,
    parameter int CYC_W      = 16,
    parameter int MAX_CYCLES = 100
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               halt_req,
    input  logic               restart,
    output logic [NUM_RST-1:0] core_rstn,
    output logic [CYC_W-1:0]   cycle_cnt,
    output logic               running,
    output logic               done,
    output logic               timeout,
    output logic [1:0]         dbg_state
);

    localparam int LAST_REL = STRETCH + (NUM_RST - 1) * STAGGER;
    localparam int TW       = $clog2(LAST_REL + 2);
    localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(MAX_CYCLES - 1);

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t             state, state_n;
    logic [1:0]         sync;
    logic [TW-1:0]      t, t_n;
    logic [NUM_RST-1:0] rel_n;
    logic [CYC_W-1:0]   cnt_n;
    logic               to_n;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync <= 2'b00;
        end else begin
            sync <= {sync[0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= HOLD;
            t         <= '0;
            core_rstn <= '0;
            cycle_cnt <= '0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_n;
            t         <= t_n;
            core_rstn <= rel_n;
            cycle_cnt <= cnt_n;
            timeout   <= to_n;
        end
    end

    // t counts edges since the arming edge (t==k just before edge Eh+k);
    // t==0 in HOLD means not yet armed. Arming fires on the edge at which
    // the synchroniser output goes high.
    always_comb begin
        state_n = state;
        t_n     = t;
        rel_n   = core_rstn;
        cnt_n   = cycle_cnt;
        to_n    = timeout;
        if (restart) begin
            state_n = HOLD;
            t_n     = TW'(1);
            rel_n   = '0;
            cnt_n   = '0;
            to_n    = 1'b0;
        end else begin
            case (state)
                HOLD: begin
                    if (t == '0) begin
                        if (sync[0]) t_n = TW'(1);
                    end else begin
                        t_n = t + TW'(1);
                        if (int'(t) == STRETCH) state_n = RELEASE;
                    end
                end
                RELEASE: begin
                    if (&core_rstn) begin
                        state_n = RUN;
                        t_n     = '0;
                        cnt_n   = '0;
                    end else begin
                        t_n = t + TW'(1);
                    end
                end
                RUN: begin
                    if (halt_req) begin
                        state_n = DONE;
                        to_n    = 1'b0;
                    end else if (cycle_cnt == LAST_CYC) begin
                        state_n = DONE;
                        to_n    = 1'b1;
                    end else begin
                        cnt_n = cycle_cnt + CYC_W'(1);
                    end
                end
                default: ;
            endcase
            if (t != '0 && (state == HOLD || state == RELEASE)) begin
                for (int i = 0; i < NUM_RST; i++) begin
                    if (int'(t) == STRETCH + i * STAGGER) rel_n[i] = 1'b1;
                end
            end
        end
    end

    assign running   = (state == RUN);
    assign done      = (state == DONE);
    assign dbg_state = state;

endmodule
